// File: rtl/sum_sched_pkg.sv
// sum_sched shared types and defaults.
// States, default sizes and index-width helper.
package sum_sched_pkg;

   localparam int D_N_OPS = 16;
   localparam int D_IN_W  = 8;
   localparam int D_OUT_W = 32;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ACCUM = 2'd1,
      S_DONE  = 2'd2
   } state_e;

   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/ADD.sv
// Plain combinational modulo-2^W adder.
// Shared adder primitive used across the datapath.
module ADD #(
   parameter int W = 32
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] y
);

   assign y = a + b;

endmodule

// File: rtl/SREG.sv
// Loadable result register with synchronous active-high reset.
// Holds its value whenever ld is low.
module SREG #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         ld,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   always_ff @(posedge clk) begin
      if (rst) begin
         q <= '0;
      end else if (ld) begin
         q <= d;
      end
   end

endmodule

// File: rtl/sum_op_sel.sv
// Operand select, mask and extend for sum_sched.
// SUM_SCHED_SIGNEXT_EN selects sign- instead of zero-extension.
module sum_op_sel
   import sum_sched_pkg::*;
#(
   parameter int N_OPS = D_N_OPS,
   parameter int IN_W  = D_IN_W,
   parameter int OUT_W = D_OUT_W,
   parameter int IDX_W = idx_w(D_N_OPS)
) (
   input  logic [N_OPS*IN_W-1:0] ops,
   input  logic [N_OPS-1:0]      mask,
   input  logic [IDX_W-1:0]      idx,
   output logic [OUT_W-1:0]      opx
);

   logic [IN_W-1:0] op;

   always_comb begin
      op  = ops[int'(idx)*IN_W +: IN_W];
`ifdef SUM_SCHED_SIGNEXT_EN
      opx = {{(OUT_W-IN_W){op[IN_W-1]}}, op};
`else
      opx = {{(OUT_W-IN_W){1'b0}}, op};
`endif
      if (!mask[idx]) begin
         opx = '0;
      end
   end

endmodule

// File: rtl/sum_sched.sv
// Single-adder operand-sum scheduler, start/busy/done handshake.
// Define SUM_SCHED_SIGNEXT_EN for signed operand extension.
module sum_sched
   import sum_sched_pkg::*;
#(
   parameter int N_OPS = D_N_OPS,
   parameter int IN_W  = D_IN_W,
   parameter int OUT_W = D_OUT_W
) (
   input  logic                  Clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [N_OPS*IN_W-1:0] ops,
   input  logic [N_OPS-1:0]      en_mask,
   output logic                  busy,
   output logic                  done,
   output logic [OUT_W-1:0]      final_sum
);

   localparam int IDX_W = idx_w(N_OPS);

   localparam logic [1:0] IDLE  = S_IDLE;
   localparam logic [1:0] ACCUM = S_ACCUM;
   localparam logic [1:0] DONE  = S_DONE;

   logic [1:0]            state;
   logic [N_OPS*IN_W-1:0] ops_q;
   logic [N_OPS-1:0]      mask_q;
   logic [IDX_W-1:0]      idx;
   logic [OUT_W-1:0]      acc;
   logic [OUT_W-1:0]      opx;
   logic [OUT_W-1:0]      sum;
   logic                  done_q;

   sum_op_sel #(
      .N_OPS (N_OPS),
      .IN_W  (IN_W),
      .OUT_W (OUT_W),
      .IDX_W (IDX_W)
   ) u_sel (
      .ops  (ops_q),
      .mask (mask_q),
      .idx  (idx),
      .opx  (opx)
   );

   ADD #(.W(OUT_W)) u_add (
      .a (acc),
      .b (opx),
      .y (sum)
   );

   SREG #(.W(OUT_W)) u_final (
      .clk (Clk),
      .rst (rst),
      .ld  (state == DONE),
      .d   (acc),
      .q   (final_sum)
   );

   always_ff @(posedge Clk) begin
      if (rst) begin
         state  <= IDLE;
         ops_q  <= '0;
         mask_q <= '0;
         idx    <= '0;
         acc    <= '0;
         done_q <= 1'b0;
      end else begin
         done_q <= (state == DONE);
         unique case (state)
            IDLE: begin
               if (start) begin
                  ops_q  <= ops;
                  mask_q <= en_mask;
                  idx    <= '0;
                  acc    <= '0;
                  state  <= ACCUM;
               end
            end
            ACCUM: begin
               // masked slots still take a cycle: fixed latency
               acc <= sum;
               idx <= idx + 1'b1;
               if (idx == IDX_W'(N_OPS-1)) begin
                  state <= DONE;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign busy = (state != IDLE);
   assign done = done_q;

endmodule

// File: tb/tb_sum_sched.sv
// Scoreboard bench for sum_sched.
// Expected sums are queued at issue, checked on done.
module tb_sum_sched;

   localparam int N  = 16;
   localparam int IW = 8;
   localparam int OW = 32;

   logic          Clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic [N*IW-1:0] ops = '0;
   logic [N-1:0]  en_mask = '0;
   logic          busy;
   logic          done;
   logic [OW-1:0] final_sum;

   int passed = 0;
   int total  = 0;
   int cyc    = 0;
   int run    = 0;

   logic [OW-1:0] exp_q[$];
   int            iss_q[$];

   sum_sched #(.N_OPS(N), .IN_W(IW), .OUT_W(OW)) dut (
      .Clk       (Clk),
      .rst       (rst),
      .start     (start),
      .ops       (ops),
      .en_mask   (en_mask),
      .busy      (busy),
      .done      (done),
      .final_sum (final_sum)
   );

   always #5 Clk = ~Clk;

   always @(posedge Clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] req);
      total++;
      if (act === req) passed++;
      else $display("FAIL %s: got %0h want %0h", name, act, req);
   endtask

   function automatic logic [N*IW-1:0] rep(input logic [IW-1:0] v);
      logic [N*IW-1:0] r;
      for (int k = 0; k < N; k++) r[k*IW +: IW] = v;
      return r;
   endfunction

   function automatic logic [N*IW-1:0] ramp();
      logic [N*IW-1:0] r;
      for (int k = 0; k < N; k++) r[k*IW +: IW] = IW'(k);
      return r;
   endfunction

   function automatic logic [N*IW-1:0] alt();
      logic [N*IW-1:0] r;
      for (int k = 0; k < N; k++) r[k*IW +: IW] = k[0] ? 8'h7F : 8'h80;
      return r;
   endfunction

   // monitor: pops one expectation per done pulse
   always @(negedge Clk) begin
      logic [OW-1:0] e;
      int            ic;
      if (rst) run = 0;
      else if (busy) run++;
      if (done) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_done", 32'd1, 32'd0);
         end else begin
            e  = exp_q.pop_front();
            ic = iss_q.pop_front();
            chk("final", final_sum, e);
            chk("latency", 32'(cyc - ic), 32'd18);
            chk("busy_len", 32'(run), 32'd17);
            chk("busy_at_done", {31'd0, busy}, 32'd0);
         end
         run = 0;
      end
   end

   // caller is positioned at a negedge
   task automatic issue_now(input logic [N*IW-1:0] o,
                            input logic [N-1:0] m,
                            input logic [OW-1:0] e);
      start   = 1'b1;
      ops     = o;
      en_mask = m;
      exp_q.push_back(e);
      iss_q.push_back(cyc);
   endtask

   task automatic issue(input logic [N*IW-1:0] o,
                        input logic [N-1:0] m,
                        input logic [OW-1:0] e);
      @(negedge Clk);
      issue_now(o, m, e);
      @(negedge Clk);
      start = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while ((exp_q.size() != 0 || busy) && n < 60) begin
         @(negedge Clk);
         n++;
      end
      if (n >= 60) chk("drain_timeout", 32'd1, 32'd0);
      @(negedge Clk);
   endtask

   task automatic wait_done();
      int n = 0;
      @(negedge Clk);
      while (!done && n < 40) begin
         @(negedge Clk);
         n++;
      end
      if (!done) chk("done_timeout", 32'd1, 32'd0);
   endtask

   initial begin
      logic [OW-1:0] ff_exp;
      logic [OW-1:0] alt_exp;
`ifdef SUM_SCHED_SIGNEXT_EN
      ff_exp  = 32'hFFFF_FFF0;
      alt_exp = 32'hFFFF_FFF8;
`else
      ff_exp  = 32'h0000_0FF0;
      alt_exp = 32'h0000_07F8;
`endif
      repeat (3) @(negedge Clk);
      rst = 1'b0;
      @(negedge Clk);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_final", final_sum, 32'd0);

      issue(rep(8'd1), 16'hFFFF, 32'd16);
      drain();
      issue(rep(8'hFF), 16'hFFFF, ff_exp);
      drain();
      issue(rep(8'd2), 16'h00FF, 32'd16);
      drain();
      issue(alt(), 16'hFFFF, alt_exp);
      drain();
      issue(ramp(), 16'h0000, 32'd0);
      drain();

      // start held while busy, ops changed after acceptance
      @(negedge Clk);
      issue_now(rep(8'd3), 16'hFFFF, 32'd48);
      repeat (10) begin
         @(negedge Clk);
         ops     = rep(8'd5);
         en_mask = 16'h0001;
      end
      start = 1'b0;
      drain();

      // restart in the done cycle
      issue(ramp(), 16'hAAAA, 32'd64);
      wait_done();
      issue_now(rep(8'd1), 16'hF00F, 32'd8);
      @(negedge Clk);
      start = 1'b0;
      drain();

      // reset mid-operation discards the sum
      @(negedge Clk);
      start   = 1'b1;
      ops     = rep(8'd9);
      en_mask = 16'hFFFF;
      @(negedge Clk);
      start = 1'b0;
      repeat (7) @(negedge Clk);
      rst = 1'b1;
      @(negedge Clk);
      rst = 1'b0;
      chk("midrst_busy", {31'd0, busy}, 32'd0);
      chk("midrst_final", final_sum, 32'd0);
      chk("midrst_done", {31'd0, done}, 32'd0);
      repeat (25) @(negedge Clk);
      chk("midrst_final_hold", final_sum, 32'd0);

      issue(ramp(), 16'hFFFF, 32'd120);
      drain();

      chk("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
